vga_timing_480p: RTL and testbench

- Pixel-clock timing generator for 640x480 at 60 Hz VGA (25.175 MHz nominal pixel clock).
- Produces the current screen coordinate (sx, sy), horizontal and vertical sync, data enable, and line/frame start strobes.
- Sits at the front of the display path. The renderer uses sx/sy as its read coordinate, and the SDL/VGA output stage samples de and the syncs.

---
 rtl/vga_timing_480p_if.sv | 14 +
 rtl/vga_timing_480p.sv | 69 ++++++
 tb/tb_vga_timing_480p.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_480p_if.sv
// vga_timing_480p_if: screen coordinate, sync, enable and strobe bundle from the timing generator
interface vga_timing_480p_if #(
  parameter int CORDW = 10
);
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic hsync;
  logic vsync;
  logic de;
  logic line;
  logic frame;
  modport master (output sx, sy, hsync, vsync, de, line, frame);
  modport slave (input sx, sy, hsync, vsync, de, line, frame);
endinterface

// File: rtl/vga_timing_480p.sv
// vga_timing_480p: 640x480@60 pixel timing generator with zero-skew registered outputs
module vga_timing_480p #(
  parameter int CORDW    = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  vga_timing_480p_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CORDW-1:0] HA  = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] HS0 = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS1 = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] HL  = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] VA  = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] VS0 = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS1 = CORDW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] VL  = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] ONE = CORDW'(1);
  logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, line_q, line_d, frame_q, frame_d;
  logic wrap;
  // Outputs decode the next coordinate so they land in the same cycle as that coordinate
  always_comb begin
    wrap    = sx_q >= HL;
    sx_d    = wrap ? '0 : sx_q + ONE;
    sy_d    = !wrap ? sy_q : (sy_q >= VL) ? '0 : sy_q + ONE;
    de_d    = (sx_d < HA) && (sy_d < VA);
    hsync_d = (sx_d >= HS0 && sx_d < HS1) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (sy_d >= VS0 && sy_d < VS1) ? SYNC_POL : ~SYNC_POL;
    line_d  = sx_d == '0;
    frame_d = (sx_d == '0) && (sy_d == '0);
  end
  always_ff @(posedge clk_pix or negedge rst_pix) begin
    if (!rst_pix) begin
      sx_q    <= HL;
      sy_q    <= VL;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end
  assign vga.sx    = sx_q;
  assign vga.sy    = sy_q;
  assign vga.hsync = hsync_q;
  assign vga.vsync = vsync_q;
  assign vga.de    = de_q;
  assign vga.line  = line_q;
  assign vga.frame = frame_q;
endmodule

// File: tb/tb_vga_timing_480p.sv
// tb_vga_timing_480p: scoreboard bench for default, reduced-size and SYNC_POL=1 timing generators
module tb_vga_timing_480p;
  logic clk_pix = 1'b0;
  logic rst_a = 1'b0;
  logic rst_m = 1'b1;
  logic rst0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;
  assign rst0 = rst_a & rst_m;
  always #5 clk_pix = ~clk_pix;
  always @(posedge clk_pix) cyc <= cyc + 1;
  vga_timing_480p_if #(.CORDW(10)) v0 ();
  vga_timing_480p_if #(.CORDW(10)) v1 ();
  vga_timing_480p_if #(.CORDW(10)) v2 ();
  vga_timing_480p u0 (.clk_pix(clk_pix), .rst_pix(rst0), .vga(v0.master));
  vga_timing_480p #(.H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
                    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(3))
    u1 (.clk_pix(clk_pix), .rst_pix(rst_a), .vga(v1.master));
  vga_timing_480p #(.SYNC_POL(1), .H_ACTIVE(320))
    u2 (.clk_pix(clk_pix), .rst_pix(rst_a), .vga(v2.master));
  typedef struct {
    int cyc;
    int id;
    logic [24:0] v;
    string nm;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [24:0] act [3];
  task automatic add(input int c, input int id, input int sx, input int sy,
                     input bit hs, input bit vs, input bit de, input bit ln, input bit fr,
                     input string nm);
    exp_t n;
    int i;
    n.cyc = c;
    n.id = id;
    n.v = {10'(sx), 10'(sy), hs, vs, de, ln, fr};
    n.nm = nm;
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, n);
  endtask
  initial begin
    add(3, 0, 799, 524, 1, 1, 0, 0, 0, "d0_reset");
    add(5, 0, 799, 524, 1, 1, 0, 0, 0, "d0_reset_hold");
    add(3, 1, 47, 30, 1, 1, 0, 0, 0, "d1_reset");
    add(3, 2, 479, 524, 0, 0, 0, 0, 0, "d2_reset");
    add(6 + 0, 0, 0, 0, 1, 1, 1, 1, 1, "d0_first_edge");
    add(6 + 639, 0, 639, 0, 1, 1, 1, 0, 0, "d0_de_last");
    add(6 + 640, 0, 640, 0, 1, 1, 0, 0, 0, "d0_de_off");
    add(6 + 655, 0, 655, 0, 1, 1, 0, 0, 0, "d0_hs_before");
    add(6 + 656, 0, 656, 0, 0, 1, 0, 0, 0, "d0_hs_start");
    add(6 + 751, 0, 751, 0, 0, 1, 0, 0, 0, "d0_hs_end");
    add(6 + 752, 0, 752, 0, 1, 1, 0, 0, 0, "d0_hs_after");
    add(6 + 799, 0, 799, 0, 1, 1, 0, 0, 0, "d0_line_end");
    add(6 + 800, 0, 0, 1, 1, 1, 1, 1, 0, "d0_line_wrap");
    add(6 + 1899, 0, 299, 2, 1, 1, 1, 0, 0, "d0_pre_async");
    add(1906, 0, 799, 524, 1, 1, 0, 0, 0, "d0_async_reset");
    add(1908, 0, 799, 524, 1, 1, 0, 0, 0, "d0_async_hold");
    add(1909 + 0, 0, 0, 0, 1, 1, 1, 1, 1, "d0_restart");
    add(1909 + 799, 0, 799, 0, 1, 1, 0, 0, 0, "d0_restart_end");
    add(1909 + 805, 0, 5, 1, 1, 1, 1, 0, 0, "d0_restart_l1");
    add(6 + 35, 1, 35, 0, 1, 1, 0, 0, 0, "d1_hs_before");
    add(6 + 36, 1, 36, 0, 0, 1, 0, 0, 0, "d1_hs_start");
    add(6 + 43, 1, 43, 0, 0, 1, 0, 0, 0, "d1_hs_end");
    add(6 + 44, 1, 44, 0, 1, 1, 0, 0, 0, "d1_hs_after");
    add(6 + 1135, 1, 31, 23, 1, 1, 1, 0, 0, "d1_last_visible");
    add(6 + 1136, 1, 32, 23, 1, 1, 0, 0, 0, "d1_de_off");
    add(6 + 1152, 1, 0, 24, 1, 1, 0, 1, 0, "d1_blank_line");
    add(6 + 1247, 1, 47, 25, 1, 1, 0, 0, 0, "d1_vs_before");
    add(6 + 1248, 1, 0, 26, 1, 0, 0, 1, 0, "d1_vs_start");
    add(6 + 1336, 1, 40, 27, 0, 0, 0, 0, 0, "d1_vs_hs");
    add(6 + 1344, 1, 0, 28, 1, 1, 0, 1, 0, "d1_vs_after");
    add(6 + 1487, 1, 47, 30, 1, 1, 0, 0, 0, "d1_frame_end");
    add(6 + 1488, 1, 0, 0, 1, 1, 1, 1, 1, "d1_frame_wrap");
    add(6 + 0, 2, 0, 0, 0, 0, 1, 1, 1, "d2_first_edge");
    add(6 + 319, 2, 319, 0, 0, 0, 1, 0, 0, "d2_de_last");
    add(6 + 320, 2, 320, 0, 0, 0, 0, 0, 0, "d2_de_off");
    add(6 + 335, 2, 335, 0, 0, 0, 0, 0, 0, "d2_hs_before");
    add(6 + 336, 2, 336, 0, 1, 0, 0, 0, 0, "d2_hs_start");
    add(6 + 431, 2, 431, 0, 1, 0, 0, 0, 0, "d2_hs_end");
    add(6 + 432, 2, 432, 0, 0, 0, 0, 0, 0, "d2_hs_after");
    add(6 + 479, 2, 479, 0, 0, 0, 0, 0, 0, "d2_line_end");
    add(6 + 480, 2, 0, 1, 0, 0, 1, 1, 0, "d2_line_wrap");
    while (cyc < 5) @(negedge clk_pix);
    #2 rst_a = 1'b1;
    while (cyc < 1905) @(negedge clk_pix);
    @(posedge clk_pix);
    #1 rst_m = 1'b0;
    while (cyc < 1908) @(negedge clk_pix);
    #2 rst_m = 1'b1;
    while (cyc < 3000 || !done) @(negedge clk_pix);
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expected at cycle %0d but never checked", e.nm, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial forever begin
    @(negedge clk_pix);
    act[0] = {v0.sx, v0.sy, v0.hsync, v0.vsync, v0.de, v0.line, v0.frame};
    act[1] = {v1.sx, v1.sy, v1.hsync, v1.vsync, v1.de, v1.line, v1.frame};
    act[2] = {v2.sx, v2.sy, v2.hsync, v2.vsync, v2.de, v2.line, v2.frame};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: missed cycle %0d", e.nm, e.cyc);
      end else if (act[e.id] !== e.v) begin
        errors++;
        $display("FAIL %s cyc=%0d: got sx=%0d sy=%0d hs/vs/de/ln/fr=%b, expected sx=%0d sy=%0d hs/vs/de/ln/fr=%b",
                 e.nm, cyc, act[e.id][24:15], act[e.id][14:5], act[e.id][4:0],
                 e.v[24:15], e.v[14:5], e.v[4:0]);
      end
    end
  end
  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask
  // Two full frames of the reduced-size generator, starting at its first frame strobe
  initial begin
    bit found = 1'b0;
    int de_n = 0, hs_n = 0, vs_n = 0, fr_n = 0, last = 0, gap = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk_pix);
      found = v1.frame;
    end
    chk("d1_frame_seen", int'(found), 1);
    if (found) begin
      for (int i = 0; i < 2976; i++) begin
        if (i > 0) @(negedge clk_pix);
        de_n += int'(v1.de);
        hs_n += int'(!v1.hsync);
        vs_n += int'(!v1.vsync);
        if (v1.frame) begin
          fr_n++;
          if (i > 0) gap = i - last;
          last = i;
        end
      end
      chk("d1_de_count", de_n, 1536);
      chk("d1_hsync_count", hs_n, 496);
      chk("d1_vsync_count", vs_n, 192);
      chk("d1_frame_count", fr_n, 2);
      chk("d1_frame_period", gap, 1488);
    end
    done = 1'b1;
  end
endmodule
